audio_mix_scheduler: RTL and testbench
======================================

// Module: audio_mix_scheduler
// PURPOSE
//  Time-multiplexed mix scheduler for the master playback buffer. Once per I2S frame (falling
//  lrclk) it snapshots all source samples, walks the sources one per mclk through a single shared
//  multiply-accumulate, saturates the sum to SAMPLE_BITS and issues one write into the master
//  sample buffer one slot behind the player's read index. Replaces the unsaturated, unscaled
//  wide adder clocked on lrclk.
// PARAMETERS
//  NUM_SRC      6    number of mixed sources (>=1)
//  SAMPLE_BITS  16   signed sample width, inputs and output
//  VOLUME_BITS  8    unsigned per-source gain width; gain = vol / 2**VOLUME_BITS
//  BUF_LEN      256  master buffer depth, power of two
//  IDX_W        8    $clog2(BUF_LEN)
// PORTS
//  mclk        in   1                       system audio clock; all logic on posedge
//  rstn        in   1                       async active-low reset
//  lrclk       in   1                       I2S frame clock, async to mclk; falling edge = new frame
//  rd_index    in   IDX_W                   player's current read index
//  src_sample  in   NUM_SRC*SAMPLE_BITS     packed signed samples, source k at [k*SB +: SB]
//  src_vol     in   NUM_SRC*VOLUME_BITS     packed unsigned gains, source k at [k*VB +: VB]
//  src_en      in   NUM_SRC                 per-source enable mask
//  clr_flags   in   1                       one-cycle pulse, clears clip and overrun
//  wr_en       out  1                       one-cycle write strobe to master buffer
//  wr_addr     out  IDX_W                   write index
//  wr_data     out  SAMPLE_BITS             saturated mixed sample
//  busy        out  1                       high from frame accept until the WRITE cycle inclusive
//  clip        out  1                       sticky: a mix saturated
//  overrun     out  1                       sticky: a frame edge arrived while busy
// BEHAVIOUR
//  - Reset (rstn low, async): state IDLE; wr_en, wr_addr, wr_data, busy, clip, overrun, acc, src
//    counter, sync flops all 0. Release is synchronised only through the normal FSM (no partial write).
//  - lrclk: 2-flop synchroniser + delay flop; frame_evt = prev & ~cur (falling), 1 mclk wide.
//  - FSM IDLE -> ACCUM -> SAT -> WRITE -> IDLE.
//    IDLE: on frame_evt latch src_sample, src_vol, src_en into snapshot regs; wr_addr <=
//      rd_index - 1 mod BUF_LEN (0 wraps to BUF_LEN-1); acc <= 0; k <= 0; busy <= 1; -> ACCUM.
//    ACCUM: one source per cycle: acc += en[k] ? (s[k] * {1'b0,vol[k]}) >>> VOLUME_BITS : 0
//      (signed product, arithmetic shift, truncates toward -inf). k increments; after k == NUM_SRC-1
//      -> SAT. Exactly NUM_SRC cycles.
//    SAT: acc width = SAMPLE_BITS + $clog2(NUM_SRC) + 1. If acc > 2**(SB-1)-1 -> max, if
//      acc < -2**(SB-1) -> min, and set clip; else pass. Result registered to wr_data. -> WRITE.
//    WRITE: wr_en = 1 for this single cycle; busy deasserts the following cycle. -> IDLE.
//  - Latency: frame_evt to wr_en = NUM_SRC + 2 mclk; lrclk fall to wr_en <= NUM_SRC + 5 mclk.
//  - Inputs changing after snapshot do not affect the current mix.
//  - frame_evt while busy (any non-IDLE state): ignored, overrun <= 1; current mix completes.
//  - frame_evt in the WRITE cycle counts as busy (overrun); accepted only in IDLE.
//  - clr_flags same cycle as a new clip/overrun event: set wins.
//  - wr_addr/wr_data hold their values between writes; only wr_en qualifies them.
//  - All sources disabled or all vol = 0: writes 0, clip unchanged.
// TESTING
//  1 Reset: rstn low mid-ACCUM -> all outputs 0 immediately, no wr_en after release until next lrclk fall.
//  2 NUM_SRC=6, src0=1000 vol 128, src1=-400 vol 255, others en=0, rd_index=10 -> one wr_en,
//    wr_addr=9, wr_data=500+(-399)=101, exactly 8 mclk after frame_evt, clip=0.
//  3 Wrap: rd_index=0 -> wr_addr=255.
//  4 Saturation: all 6 sources 30000 vol 255 -> wr_data=32767, clip=1; all -30000 -> -32768;
//    clr_flags pulse -> clip=0.
//  5 Overrun: second lrclk fall forced 3 mclk after first -> overrun=1, exactly one wr_en, data
//    from first snapshot.
//  6 Snapshot: change src_sample during ACCUM -> wr_data reflects values latched at frame_evt.

Source files
------------

// File: rtl/audio_mix_scheduler_if.sv
// Bus bundle for the audio mix scheduler: frame clock, source snapshot inputs,
// master-buffer write port and status flags.
interface audio_mix_scheduler_if #(
  parameter int NUM_SRC     = 6,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int IDX_W       = 8
);
  logic                              lrclk;
  logic [IDX_W-1:0]                  rd_index;
  logic [NUM_SRC*SAMPLE_BITS-1:0]    src_sample;
  logic [NUM_SRC*VOLUME_BITS-1:0]    src_vol;
  logic [NUM_SRC-1:0]                src_en;
  logic                              clr_flags;
  logic                              wr_en;
  logic [IDX_W-1:0]                  wr_addr;
  logic signed [SAMPLE_BITS-1:0]     wr_data;
  logic                              busy;
  logic                              clip;
  logic                              overrun;

  modport slave (
    input  lrclk, rd_index, src_sample, src_vol, src_en, clr_flags,
    output wr_en, wr_addr, wr_data, busy, clip, overrun
  );

  modport master (
    output lrclk, rd_index, src_sample, src_vol, src_en, clr_flags,
    input  wr_en, wr_addr, wr_data, busy, clip, overrun
  );
endinterface

// File: rtl/audio_mix_scheduler.sv
// Per-frame mix scheduler: snapshots all sources on a falling lrclk, accumulates
// one scaled source per mclk, saturates and writes one slot behind the player.
module audio_mix_scheduler #(
  parameter int NUM_SRC     = 6,
  parameter int SAMPLE_BITS = 16,
  parameter int VOLUME_BITS = 8,
  parameter int BUF_LEN     = 256,
  parameter int IDX_W       = 8
) (
  input logic                   mclk,
  input logic                   rstn,
  audio_mix_scheduler_if.slave  bus
);

  localparam int SB    = SAMPLE_BITS;
  localparam int VB    = VOLUME_BITS;
  localparam int ACC_W = SB + $clog2(NUM_SRC) + 1;
  localparam int K_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (SB - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_SAT, S_WRITE} state_t;

  // Gain is vol / 2**VB; the arithmetic shift floors toward -inf.
  function automatic logic signed [ACC_W-1:0] scale_term(
    input logic signed [SB-1:0] s,
    input logic        [VB-1:0] v
  );
    logic signed [SB+VB:0] prod;
    prod = s * $signed({1'b0, v});
    return ACC_W'(prod >>> VB);
  endfunction

  function automatic logic is_clipped(input logic signed [ACC_W-1:0] a);
    return (a > SAT_MAX) || (a < SAT_MIN);
  endfunction

  function automatic logic signed [SB-1:0] saturate(input logic signed [ACC_W-1:0] a);
    if (a > SAT_MAX)      return {1'b0, {(SB-1){1'b1}}};
    else if (a < SAT_MIN) return {1'b1, {(SB-1){1'b0}}};
    else                  return a[SB-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic                    sync1_q, sync2_q, prev_q;
  logic                    frame_evt;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [K_W-1:0]   k_q, k_d;
  logic        [IDX_W-1:0] addr_q, addr_d;
  logic signed [SB-1:0]    data_q, data_d;
  logic                    wr_en_q, wr_en_d;
  logic                    busy_q, busy_d;
  logic                    clip_q, clip_d;
  logic                    ovr_q, ovr_d;
  logic                    snap_load;
  logic                    clip_set;
  logic                    ovr_set;
  logic signed [ACC_W-1:0] term;

  logic signed [SB-1:0]    smp_q [NUM_SRC];
  logic        [VB-1:0]    vol_q [NUM_SRC];
  logic        [NUM_SRC-1:0] en_q;

  assign frame_evt = prev_q & ~sync2_q;

  // Synchroniser and control state
  always_ff @(posedge mclk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= S_IDLE;
      acc_q   <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      clip_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sync1_q <= bus.lrclk;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      acc_q   <= acc_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      clip_q  <= clip_d;
      ovr_q   <= ovr_d;
    end
  end

  // Source snapshot: pure data, only meaningful after an accepted frame
  always_ff @(posedge mclk) begin
    if (snap_load) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        smp_q[k] <= bus.src_sample[k*SB +: SB];
        vol_q[k] <= bus.src_vol[k*VB +: VB];
      end
      en_q <= bus.src_en;
    end
  end

  always_comb begin
    term = '0;
    if (en_q[k_q]) term = scale_term(smp_q[k_q], vol_q[k_q]);
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    k_d       = k_q;
    addr_d    = addr_q;
    data_d    = data_q;
    snap_load = 1'b0;
    clip_set  = 1'b0;
    ovr_set   = frame_evt && (state_q != S_IDLE);

    unique case (state_q)
      S_IDLE: begin
        if (frame_evt) begin
          snap_load = 1'b1;
          addr_d    = bus.rd_index - 1'b1;
          acc_d     = '0;
          k_d       = '0;
          state_d   = S_ACCUM;
        end
      end
      S_ACCUM: begin
        acc_d = acc_q + term;
        if (k_q == K_W'(NUM_SRC - 1)) state_d = S_SAT;
        else                          k_d     = k_q + 1'b1;
      end
      S_SAT: begin
        data_d   = saturate(acc_q);
        clip_set = is_clipped(acc_q);
        state_d  = S_WRITE;
      end
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A new clip/overrun event outranks a clear in the same cycle.
    wr_en_d = (state_d == S_WRITE);
    busy_d  = (state_d != S_IDLE);
    clip_d  = (clip_q & ~bus.clr_flags) | clip_set;
    ovr_d   = (ovr_q  & ~bus.clr_flags) | ovr_set;
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;
  assign bus.busy    = busy_q;
  assign bus.clip    = clip_q;
  assign bus.overrun = ovr_q;

endmodule

// File: tb/tb_audio_mix_scheduler.sv
// Directed and randomized bench for audio_mix_scheduler with a per-frame
// arithmetic reference model of the mix, saturation and sticky flags.
module tb_audio_mix_scheduler;
  localparam int NS = 6;
  localparam int SB = 16;
  localparam int VB = 8;
  localparam int BL = 256;
  localparam int IW = 8;

  logic mclk = 1'b0;
  logic rstn = 1'b1;
  always #5 mclk = ~mclk;

  audio_mix_scheduler_if #(.NUM_SRC(NS), .SAMPLE_BITS(SB), .VOLUME_BITS(VB), .IDX_W(IW)) bus ();

  audio_mix_scheduler #(.NUM_SRC(NS), .SAMPLE_BITS(SB), .VOLUME_BITS(VB),
                        .BUF_LEN(BL), .IDX_W(IW)) dut (
    .mclk (mclk),
    .rstn (rstn),
    .bus  (bus)
  );

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int wr_cnt  = 0;
  int smp [NS];
  int vol [NS];
  bit en  [NS];
  bit m_clip = 1'b0;
  bit m_ovr  = 1'b0;

  always @(negedge mclk) if (bus.wr_en === 1'b1) wr_cnt++;

  task automatic tick();
    @(posedge mclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply();
    for (int k = 0; k < NS; k++) begin
      bus.src_sample[k*SB +: SB] = SB'(smp[k]);
      bus.src_vol[k*VB +: VB]    = VB'(vol[k]);
      bus.src_en[k]              = en[k];
    end
  endtask

  // Scaled contribution is floor(sample * vol / 256), done with integer division.
  function automatic int ref_mix();
    int sum;
    sum = 0;
    for (int k = 0; k < NS; k++) begin
      if (en[k]) begin
        int p;
        int q;
        p = smp[k] * vol[k];
        q = p / 256;
        if (p < 0 && (p % 256) != 0) q = q - 1;
        sum += q;
      end
    end
    return sum;
  endfunction

  function automatic int ref_sat(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  task automatic randomize_srcs();
    for (int k = 0; k < NS; k++) begin
      smp[k] = int'($urandom_range(65535)) - 32768;
      vol[k] = int'($urandom_range(255));
      en[k]  = 1'($urandom_range(1));
    end
  endtask

  task automatic clear_flags();
    bus.clr_flags = 1'b1;
    tick();
    bus.clr_flags = 1'b0;
    m_clip = 1'b0;
    m_ovr  = 1'b0;
    chk("clr_clip", bus.clip, m_clip);
    chk("clr_ovr", bus.overrun, m_ovr);
  endtask

  // One falling lrclk, then check latency, write port, flags and a single write.
  task automatic frame(input string tag, input bit scramble);
    int n, c0, sum, exp_data, exp_addr;
    sum      = ref_mix();
    exp_data = ref_sat(sum);
    if (sum != exp_data) m_clip = 1'b1;
    exp_addr = (int'(bus.rd_index) + BL - 1) % BL;
    c0 = wr_cnt;
    bus.lrclk = 1'b0;
    n = 0;
    while (bus.wr_en !== 1'b1 && n < 20) begin
      tick();
      n++;
      if (scramble && n == 5) begin
        bus.src_sample = {$urandom, $urandom, $urandom};
        bus.src_vol    = 48'({$urandom, $urandom});
        bus.src_en     = ~bus.src_en;
        bus.rd_index   = bus.rd_index + 8'd77;
      end
    end
    chk({tag, "_lat"}, n, 10);
    chk({tag, "_addr"}, bus.wr_addr, exp_addr);
    chk({tag, "_data"}, $signed(bus.wr_data), exp_data);
    chk({tag, "_clip"}, bus.clip, m_clip);
    chk({tag, "_ovr"}, bus.overrun, m_ovr);
    chk({tag, "_busyw"}, bus.busy, 1);
    tick();
    chk({tag, "_wren_off"}, bus.wr_en, 0);
    chk({tag, "_busy_off"}, bus.busy, 0);
    bus.lrclk = 1'b1;
    repeat (3) tick();
    chk({tag, "_nwr"}, wr_cnt - c0, 1);
  endtask

  initial begin
    int c0, n, exp_data, exp_addr;
    bus.lrclk      = 1'b1;
    bus.rd_index   = '0;
    bus.src_sample = '0;
    bus.src_vol    = '0;
    bus.src_en     = '0;
    bus.clr_flags  = 1'b0;
    for (int k = 0; k < NS; k++) begin smp[k] = 0; vol[k] = 0; en[k] = 0; end

    #1 rstn = 1'b0;
    repeat (3) tick();
    chk("rst_wren", bus.wr_en, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_data", bus.wr_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_clip", bus.clip, 0);
    chk("rst_ovr", bus.overrun, 0);
    rstn = 1'b1;
    repeat (4) tick();

    // Basic two-source mix: 500 + (-399)
    randomize_srcs();
    smp[0] = 1000; vol[0] = 128; en[0] = 1;
    smp[1] = -400; vol[1] = 255; en[1] = 1;
    for (int k = 2; k < NS; k++) en[k] = 0;
    apply();
    bus.rd_index = 8'd10;
    frame("mix2", 1'b0);

    bus.rd_index = 8'd0;
    frame("wrap", 1'b0);

    for (int k = 0; k < NS; k++) begin smp[k] = 30000; vol[k] = 255; en[k] = 1; end
    apply();
    bus.rd_index = 8'd33;
    frame("satpos", 1'b0);
    clear_flags();
    for (int k = 0; k < NS; k++) smp[k] = -30000;
    apply();
    frame("satneg", 1'b0);
    clear_flags();

    for (int k = 0; k < NS; k++) begin smp[k] = 30000; vol[k] = 200; en[k] = 0; end
    apply();
    frame("alloff", 1'b0);

    randomize_srcs();
    apply();
    bus.rd_index = IW'($urandom);
    frame("snap", 1'b1);

    // Second falling edge 3 mclk after the first, while the mix is in flight
    randomize_srcs();
    apply();
    bus.rd_index = 8'd100;
    exp_data = ref_sat(ref_mix());
    if (ref_mix() != exp_data) m_clip = 1'b1;
    exp_addr = 99;
    c0 = wr_cnt;
    bus.lrclk = 1'b0;
    tick();
    bus.lrclk = 1'b1;
    tick();
    tick();
    bus.lrclk = 1'b0;
    bus.src_sample = {$urandom, $urandom, $urandom};
    bus.rd_index   = 8'd5;
    n = 0;
    while (bus.wr_en !== 1'b1 && n < 20) begin tick(); n++; end
    m_ovr = 1'b1;
    chk("ovr_data", $signed(bus.wr_data), exp_data);
    chk("ovr_addr", bus.wr_addr, exp_addr);
    chk("ovr_flag", bus.overrun, m_ovr);
    repeat (15) tick();
    chk("ovr_nwr", wr_cnt - c0, 1);
    bus.lrclk = 1'b1;
    repeat (3) tick();
    clear_flags();

    for (int i = 0; i < 10; i++) begin
      randomize_srcs();
      if (i == 3) for (int k = 0; k < NS; k++) begin smp[k] = 32767; vol[k] = 255; en[k] = 1; end
      apply();
      bus.rd_index = IW'($urandom);
      frame("rand", 1'b0);
      if (i == 5) clear_flags();
    end

    // Reset while accumulating
    randomize_srcs();
    apply();
    bus.lrclk = 1'b0;
    repeat (5) tick();
    chk("pre_rst_busy", bus.busy, 1);
    #2 rstn = 1'b0;
    #1;
    m_clip = 1'b0;
    m_ovr  = 1'b0;
    chk("arst_wren", bus.wr_en, 0);
    chk("arst_addr", bus.wr_addr, 0);
    chk("arst_data", bus.wr_data, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_clip", bus.clip, 0);
    chk("arst_ovr", bus.overrun, 0);
    tick();
    rstn = 1'b1;
    c0 = wr_cnt;
    repeat (15) tick();
    bus.lrclk = 1'b1;
    repeat (5) tick();
    chk("arst_nwr", wr_cnt - c0, 0);
    chk("arst_idle", bus.busy, 0);

    randomize_srcs();
    apply();
    bus.rd_index = IW'($urandom);
    frame("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end
endmodule
